// File: rtl/instr_encode_writer_pkg.sv
// Shared instruction-format definitions: opcodes, field positions, FSM state type.
// Latency: none (declarations only).
// Backpressure: not applicable.
package instr_encode_writer_pkg;

   // Opcode / op-field encodings that allow the immediate format
   localparam logic [2:0] OPC_MOV    = 3'b110;
   localparam logic [2:0] OPC_LDR    = 3'b011;
   localparam logic [2:0] OPC_STR    = 3'b100;
   localparam logic [1:0] OP_MOVIMM  = 2'b10;

   // Instruction word width
   localparam int INSTR_W = 16;

   // Field bit positions, shared with the decoder
   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 13;
   localparam int OP_MSB  = 12;
   localparam int OP_LSB  = 11;
   localparam int RN_MSB  = 10;
   localparam int RN_LSB  = 8;
   localparam int RD_MSB  = 7;
   localparam int RD_LSB  = 5;
   localparam int SH_MSB  = 4;
   localparam int SH_LSB  = 3;
   localparam int RM_MSB  = 2;
   localparam int RM_LSB  = 0;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   // Loader FSM states
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCEPT = 2'd1,
      S_WRITE  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   // Immediate format is only meaningful for MOV-immediate, LDR and STR
   function automatic logic imm_legal(input logic [2:0] opcode, input logic [1:0] op);
      return ((opcode == OPC_MOV) && (op == OP_MOVIMM)) ||
             (opcode == OPC_LDR) ||
             (opcode == OPC_STR);
   endfunction

endpackage

// File: rtl/instr_encode_writer_if.sv
// Host-side field bundle, session control and memory write port of the loader.
// Latency: none (wiring only).
// Backpressure: in_valid/in_ready on fields, mem_we held until mem_ack on memory.
interface instr_encode_writer_if #(
   parameter int ADDR_W = 8
);
   // Session control
   logic              start;
   logic [ADDR_W-1:0] base_addr;

   // Field bundle handshake
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_opcode;
   logic [1:0]        in_op;
   logic [2:0]        in_rn;
   logic [2:0]        in_rd;
   logic [1:0]        in_sh;
   logic [2:0]        in_rm;
   logic              in_use_imm;
   logic [7:0]        in_imm8;
   logic              in_last;

   // Instruction memory write port
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;
   logic              mem_ack;

   // Session status
   logic              done;
   logic              full;
   logic              err;
   logic [ADDR_W:0]   words_written;

   // Host / memory side
   modport master (
      output start, base_addr,
      output in_valid, in_opcode, in_op, in_rn, in_rd, in_sh, in_rm,
      output in_use_imm, in_imm8, in_last,
      input  in_ready,
      input  mem_we, mem_addr, mem_wdata,
      output mem_ack,
      input  done, full, err, words_written
   );

   // Loader side
   modport slave (
      input  start, base_addr,
      input  in_valid, in_opcode, in_op, in_rn, in_rd, in_sh, in_rm,
      input  in_use_imm, in_imm8, in_last,
      output in_ready,
      output mem_we, mem_addr, mem_wdata,
      input  mem_ack,
      output done, full, err, words_written
   );

endinterface

// File: rtl/instr_encode_writer_pack.sv
// Packs decoded fields into a 16-bit instruction word and flags illegal immediates.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
module instr_encode_writer_pack
   import instr_encode_writer_pkg::*;
(
   input  logic [2:0]         i_opcode,
   input  logic [1:0]         i_op,
   input  logic [2:0]         i_rn,
   input  logic [2:0]         i_rd,
   input  logic [1:0]         i_sh,
   input  logic [2:0]         i_rm,
   input  logic               i_use_imm,
   input  logic [7:0]         i_imm8,
   output logic [INSTR_W-1:0] o_word,
   output logic               o_legal
);

   // Place each field at its shared bit position; low byte depends on format
   always_comb begin
      o_word  = '0;
      o_legal = 1'b1;
      o_word[OPC_MSB:OPC_LSB] = i_opcode;
      o_word[OP_MSB:OP_LSB]   = i_op;
      o_word[RN_MSB:RN_LSB]   = i_rn;
      if (i_use_imm) begin
         o_word[IMM_MSB:IMM_LSB] = i_imm8;
         o_legal = imm_legal(i_opcode, i_op);
      end else begin
         o_word[RD_MSB:RD_LSB] = i_rd;
         o_word[SH_MSB:SH_LSB] = i_sh;
         o_word[RM_MSB:RM_LSB] = i_rm;
      end
   end

endmodule

// File: rtl/instr_encode_writer.sv
// Loader: accepts field bundles, packs them and writes words sequentially from base_addr.
// Latency: accept at edge N -> mem_we in cycle N+1; best case one word per 2 cycles.
// Backpressure: in_ready only in ACCEPT; mem_we/addr/data held until mem_ack.
module instr_encode_writer
   import instr_encode_writer_pkg::*;
#(
   parameter int              ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}}
) (
   input  logic clk,
   input  logic reset,
   instr_encode_writer_if.slave bus
);

   localparam logic [ADDR_W:0]   WORDS_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

   state_t               r_state;
   state_t               w_next;
   logic [ADDR_W-1:0]    r_addr;
   logic [INSTR_W-1:0]   r_wdata;
   logic                 r_last;
   logic [ADDR_W:0]      r_words;
   logic                 r_full;
   logic                 r_err;

   logic [INSTR_W-1:0]   w_word;
   logic                 w_legal;
   logic                 w_accept;
   logic                 w_commit;
   logic                 w_at_end;

   instr_encode_writer_pack u_pack (
      .i_opcode  (bus.in_opcode),
      .i_op      (bus.in_op),
      .i_rn      (bus.in_rn),
      .i_rd      (bus.in_rd),
      .i_sh      (bus.in_sh),
      .i_rm      (bus.in_rm),
      .i_use_imm (bus.in_use_imm),
      .i_imm8    (bus.in_imm8),
      .o_word    (w_word),
      .o_legal   (w_legal)
   );

   assign w_accept = (r_state == S_ACCEPT) && bus.in_valid;
   assign w_commit = (r_state == S_WRITE) && bus.mem_ack;
   assign w_at_end = (r_addr == LAST_ADDR);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state: rejected bundles stay in ACCEPT unless they close the session
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_next = S_ACCEPT;
            end
         end
         S_ACCEPT: begin
            if (w_accept) begin
               if (w_legal) begin
                  w_next = S_WRITE;
               end else if (bus.in_last) begin
                  w_next = S_DONE;
               end
            end
         end
         S_WRITE: begin
            if (bus.mem_ack) begin
               if (w_at_end || r_last) begin
                  w_next = S_DONE;
               end else begin
                  w_next = S_ACCEPT;
               end
            end
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Session datapath: address counter, word register, counters and status flags
   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_last  <= 1'b0;
         r_words <= '0;
         r_full  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_err <= w_accept && !w_legal;
         if ((r_state == S_IDLE) && bus.start) begin
            r_addr  <= bus.base_addr;
            r_words <= '0;
            r_full  <= 1'b0;
         end
         if (w_accept && w_legal) begin
            r_wdata <= w_word;
            r_last  <= bus.in_last;
         end
         // No wrap: the top address ends the session instead of incrementing
         if (w_commit) begin
            r_words <= r_words + WORDS_ONE;
            if (w_at_end) begin
               r_full <= 1'b1;
            end else if (!r_last) begin
               r_addr <= r_addr + ADDR_ONE;
            end
         end
      end
   end

   // Outputs come only from registers or state decode
   assign bus.in_ready      = (r_state == S_ACCEPT);
   assign bus.mem_we        = (r_state == S_WRITE);
   assign bus.done          = (r_state == S_DONE);
   assign bus.mem_addr      = r_addr;
   assign bus.mem_wdata     = r_wdata;
   assign bus.full          = r_full;
   assign bus.err           = r_err;
   assign bus.words_written = r_words;

endmodule

// File: tb/tb_instr_encode_writer.sv
// Directed bench for instr_encode_writer with a write scoreboard.
// Inputs driven and outputs sampled on the falling edge.
module tb_instr_encode_writer;

   localparam int AW = 8;
   localparam logic [AW-1:0] LAST = 8'hFF;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   instr_encode_writer_if #(.ADDR_W(AW)) bus ();

   instr_encode_writer #(.ADDR_W(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [15:0]   data;
   } wr_t;

   wr_t           sb[$];
   logic [AW-1:0] exp_addr;
   int            exp_words;
   int            n_checks = 0;
   int            n_pass   = 0;

   function automatic logic [15:0] model_word(input logic [2:0] opc, input logic [1:0] op,
                                              input logic [2:0] rn, input logic [2:0] rd,
                                              input logic [1:0] sh, input logic [2:0] rm,
                                              input logic use_imm, input logic [7:0] imm8);
      if (use_imm) return {opc, op, rn, imm8};
      return {opc, op, rn, rd, sh, rm};
   endfunction

   function automatic logic model_legal(input logic [2:0] opc, input logic [1:0] op,
                                        input logic use_imm);
      if (!use_imm) return 1'b1;
      return (opc == 3'b110 && op == 2'b10) || opc == 3'b011 || opc == 3'b100;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic do_start(input logic [AW-1:0] base);
      bus.start     = 1'b1;
      bus.base_addr = base;
      @(negedge clk);
      bus.start = 1'b0;
      exp_addr  = base;
      exp_words = 0;
      chk("start_in_ready", 32'(bus.in_ready), 32'd1);
      chk("start_words", 32'(bus.words_written), 32'd0);
      chk("start_full", 32'(bus.full), 32'd0);
   endtask

   task automatic send(input logic [2:0] opc, input logic [1:0] op, input logic [2:0] rn,
                       input logic [2:0] rd, input logic [1:0] sh, input logic [2:0] rm,
                       input logic use_imm, input logic [7:0] imm8, input logic last);
      int   w = 0;
      logic legal;
      wr_t  e;
      while (bus.in_ready !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
      bus.in_opcode  = opc;
      bus.in_op      = op;
      bus.in_rn      = rn;
      bus.in_rd      = rd;
      bus.in_sh      = sh;
      bus.in_rm      = rm;
      bus.in_use_imm = use_imm;
      bus.in_imm8    = imm8;
      bus.in_last    = last;
      bus.in_valid   = 1'b1;
      legal = model_legal(opc, op, use_imm);
      if (legal) begin
         e.addr = exp_addr;
         e.data = model_word(opc, op, rn, rd, sh, rm, use_imm, imm8);
         sb.push_back(e);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("we_after_accept", 32'(bus.mem_we), 32'(legal));
      chk("err_after_accept", 32'(bus.err), 32'(!legal));
   endtask

   task automatic service(input int delay, input logic last);
      int  w = 0;
      wr_t e;
      while (bus.mem_we !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("mem_we_wait", 32'(bus.mem_we), 32'd1);
      chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      chk("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
      chk("wr_data", 32'(bus.mem_wdata), 32'(e.data));
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         chk("hold_we", 32'(bus.mem_we), 32'd1);
         chk("hold_addr", 32'(bus.mem_addr), 32'(e.addr));
         chk("hold_data", 32'(bus.mem_wdata), 32'(e.data));
      end
      bus.mem_ack = 1'b1;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      exp_words++;
      if (exp_addr != LAST && !last) exp_addr = exp_addr + 8'd1;
   endtask

   task automatic chk_done(input int words, input logic full);
      chk("done_pulse", 32'(bus.done), 32'd1);
      chk("done_words", 32'(bus.words_written), 32'(words));
      chk("done_full", 32'(bus.full), 32'(full));
      chk("done_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      chk("done_clear", 32'(bus.done), 32'd0);
      chk("idle_words_held", 32'(bus.words_written), 32'(words));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
      chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
      chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
      chk({tag, "_done"}, 32'(bus.done), 32'd0);
      chk({tag, "_full"}, 32'(bus.full), 32'd0);
      chk({tag, "_err"}, 32'(bus.err), 32'd0);
      chk({tag, "_words"}, 32'(bus.words_written), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b1;
      bus.start      = 1'b0;
      bus.base_addr  = '0;
      bus.in_valid   = 1'b0;
      bus.in_opcode  = '0;
      bus.in_op      = '0;
      bus.in_rn      = '0;
      bus.in_rd      = '0;
      bus.in_sh      = '0;
      bus.in_rm      = '0;
      bus.in_use_imm = 1'b0;
      bus.in_imm8    = '0;
      bus.in_last    = 1'b0;
      bus.mem_ack    = 1'b0;
      exp_addr       = '0;
      exp_words      = 0;
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      reset = 1'b0;
      @(negedge clk);

      // Single register-format word, immediate ack
      do_start(8'h10);
      send(3'b101, 2'b00, 3'd1, 3'd2, 2'b00, 3'd3, 1'b0, 8'h00, 1'b1);
      chk("t1_addr_const", 32'(bus.mem_addr), 32'h10);
      chk("t1_data_const", 32'(bus.mem_wdata), 32'hA143);
      service(0, 1'b1);
      chk_done(1, 1'b0);

      // MOV immediate, then illegal immediate, then LDR immediate at unchanged address
      do_start(8'h20);
      send(3'b110, 2'b10, 3'd0, 3'd0, 2'b00, 3'd0, 1'b1, 8'h07, 1'b0);
      chk("t2_data_const", 32'(bus.mem_wdata), 32'hD007);
      service(0, 1'b0);
      send(3'b101, 2'b00, 3'd4, 3'd0, 2'b00, 3'd0, 1'b1, 8'h33, 1'b0);
      chk("t2_err_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      chk("t2_err_clear", 32'(bus.err), 32'd0);
      chk("t2_no_we", 32'(bus.mem_we), 32'd0);
      send(3'b011, 2'b01, 3'd2, 3'd0, 2'b00, 3'd0, 1'b1, 8'h5A, 1'b1);
      chk("t2_addr_const", 32'(bus.mem_addr), 32'h21);
      service(0, 1'b1);
      chk_done(2, 1'b0);

      // Three words with delayed acks
      do_start(8'h40);
      send(3'b001, 2'b11, 3'd7, 3'd6, 2'b10, 3'd5, 1'b0, 8'h00, 1'b0);
      service(3, 1'b0);
      send(3'b100, 2'b00, 3'd3, 3'd0, 2'b00, 3'd0, 1'b1, 8'hC3, 1'b0);
      service(3, 1'b0);
      send(3'b010, 2'b01, 3'd5, 3'd1, 2'b01, 3'd6, 1'b0, 8'h00, 1'b1);
      chk("t3_addr_const", 32'(bus.mem_addr), 32'h42);
      service(3, 1'b1);
      chk_done(3, 1'b0);

      // Memory runs out: two writes from LAST-1, then full
      do_start(LAST - 8'd1);
      send(3'b000, 2'b01, 3'd1, 3'd1, 2'b01, 3'd1, 1'b0, 8'h00, 1'b0);
      service(0, 1'b0);
      send(3'b111, 2'b10, 3'd2, 3'd2, 2'b10, 3'd2, 1'b0, 8'h00, 1'b0);
      chk("t4_last_addr", 32'(bus.mem_addr), 32'hFF);
      service(0, 1'b0);
      bus.in_valid = 1'b1;
      chk_done(2, 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk("t4_no_accept", 32'(bus.in_ready), 32'd0);
         chk("t4_full_held", 32'(bus.full), 32'd1);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;

      // Reset during a stalled write
      do_start(8'h30);
      send(3'b101, 2'b01, 3'd6, 3'd3, 2'b11, 3'd4, 1'b0, 8'h00, 1'b0);
      @(negedge clk);
      chk("t5_stalled_we", 32'(bus.mem_we), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      sb.delete();
      chk_reset_vals("t5_rst");
      reset = 1'b0;
      @(negedge clk);
      chk_reset_vals("t5_idle");
      do_start(8'h50);
      send(3'b011, 2'b00, 3'd1, 3'd0, 2'b00, 3'd0, 1'b1, 8'hA5, 1'b1);
      chk("t5_data_const", 32'(bus.mem_wdata), 32'h61A5);
      service(1, 1'b1);
      chk_done(1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
